// File: rtl/rotor_enigma_stream_pkg.sv
// Shared constants and helpers for the rotor cipher stream.
// Alphabet size, ASCII base, rotor keys and mod-26 reduction.
package rotor_enigma_stream_pkg;

   localparam int ALPHA = 26;
   localparam logic [7:0] ASCII_A = 8'h41;

   function automatic logic [4:0] rotor_key(input int i);
      return 5'(2 * i + 1);
   endfunction

   function automatic logic [4:0] mod26(input logic [7:0] v);
      return 5'(v % 8'(ALPHA));
   endfunction

endpackage

// File: rtl/rotor_enigma_stream_if.sv
// Character stream handshake bundle.
// Input side valid/ready/char and output side valid/ready/char.
interface rotor_enigma_stream_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_char;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_char;

   modport master (
      output in_valid, in_char, out_ready,
      input  in_ready, out_valid, out_char
   );

   modport slave (
      input  in_valid, in_char, out_ready,
      output in_ready, out_valid, out_char
   );

endinterface

// File: rtl/rotor_enigma_stream_rotors.sv
// Odometer-style rotor positions with load and step.
// Exports S, the keyed position sum of the current positions.
module enigma_rotor_stack
   import rotor_enigma_stream_pkg::*;
#(
   parameter int NUM_ROTORS = 3,
   parameter int POS_W      = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load,
   input  logic [NUM_ROTORS*POS_W-1:0] start_pos,
   input  logic                        step,
   output logic [6:0]                  s_sum
);

   logic [POS_W-1:0]      pos [NUM_ROTORS];
   logic [NUM_ROTORS-1:0] carry;

   // carry ripples up while lower rotors sit on their last letter
   always_comb begin
      carry[0] = step;
      for (int i = 1; i < NUM_ROTORS; i++)
         carry[i] = carry[i-1] && (pos[i-1] == POS_W'(ALPHA - 1));
   end

   // keyed position sum sampled by the pipeline before stepping
   always_comb begin
      s_sum = '0;
      for (int i = 0; i < NUM_ROTORS; i++)
         s_sum = s_sum + 7'(mod26(8'(pos[i]) + 8'(rotor_key(i))));
   end

   // positions: reset, load with single wrap fold, or step
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_ROTORS; i++) begin
         if (rst)
            pos[i] <= '0;
         else if (load)
            pos[i] <= (start_pos[i*POS_W +: POS_W] >= POS_W'(ALPHA))
                    ? start_pos[i*POS_W +: POS_W] - POS_W'(ALPHA)
                    : start_pos[i*POS_W +: POS_W];
         else if (carry[i])
            pos[i] <= (pos[i] == POS_W'(ALPHA - 1)) ? '0 : pos[i] + 1'b1;
      end
   end

endmodule

// File: rtl/rotor_enigma_stream.sv
// Two-stage reciprocal rotor cipher on an ASCII stream.
// Letters are substituted; everything else passes unchanged.
module rotor_enigma_stream
   import rotor_enigma_stream_pkg::*;
#(
   parameter int NUM_ROTORS = 3,
   parameter int POS_W      = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load,
   input  logic [NUM_ROTORS*POS_W-1:0] start_pos,
   rotor_enigma_stream_if.slave        bus
);

   logic       advance;
   logic       accept;
   logic       is_letter;
   logic [6:0] s_sum;

   logic       v1;
   logic       l1;
   logic [7:0] c1;
   logic [4:0] x1;
   logic [6:0] s1;

   logic       ov_q;
   logic [7:0] oc_q;
   logic [4:0] t2;
   logic [4:0] idx;

   assign advance      = !ov_q || bus.out_ready;
   assign bus.in_ready = advance && !load && !rst;
   assign accept       = bus.in_valid && bus.in_ready;
   assign is_letter    = (bus.in_char >= ASCII_A)
                      && (bus.in_char <= 8'h5A);

   assign bus.out_valid = ov_q;
   assign bus.out_char  = oc_q;

   // 77 = 25 + 52 keeps the difference positive before reducing
   assign t2  = mod26({s1, 1'b0});
   assign idx = mod26(8'd77 - 8'(x1) - 8'(t2));

   enigma_rotor_stack #(
      .NUM_ROTORS (NUM_ROTORS),
      .POS_W      (POS_W)
   ) u_rotors (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .start_pos (start_pos),
      .step      (accept && is_letter),
      .s_sum     (s_sum)
   );

   // stage 1: capture class, letter index and pre-step S
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         l1 <= 1'b0;
         c1 <= '0;
         x1 <= '0;
         s1 <= '0;
      end else if (advance) begin
         v1 <= accept;
         l1 <= is_letter;
         c1 <= bus.in_char;
         x1 <= bus.in_char[4:0] - 5'(ASCII_A);
         s1 <= s_sum;
      end
   end

   // stage 2: substituted or passed-through output character
   always_ff @(posedge clk) begin
      if (rst) begin
         ov_q <= 1'b0;
         oc_q <= '0;
      end else if (advance) begin
         ov_q <= v1;
         oc_q <= l1 ? ASCII_A + 8'(idx) : c1;
      end
   end

endmodule

// File: doc/rotor_enigma_stream.md
ROTOR_ENIGMA_STREAM -- requirements
Module: rotor_enigma_stream

Interface
REQ-001 Parameter NUM_ROTORS, default 3, number of cascaded stepping rotors (legal 1..4).
REQ-002 Parameter POS_W, default 5, width of one rotor position field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  strobe: load start_pos into all rotors.
REQ-006 start_pos  input  NUM_ROTORS*POS_W  rotor start positions; rotor i in bits [i*POS_W +: POS_W].
REQ-007 in_valid  input  1  in_char presented.
REQ-008 in_ready  output  1  block accepts in_char this cycle.
REQ-009 in_char  input  8  ASCII input character.
REQ-010 out_valid  output  1  out_char holds a result.
REQ-011 out_ready  input  1  downstream consumes out_char this cycle.
REQ-012 out_char  output  8  ASCII result character.

Function
REQ-013 Accept occurs on in_valid && in_ready; emit occurs on out_valid && out_ready.
REQ-014 Letter = in_char in 'A'..'Z' (0x41..0x5A); index x = in_char - 0x41; all other codes are non-letters.
REQ-015 Non-letters pass to out_char unchanged and never step rotors.
REQ-016 Letter output index = (25 - x - 2*S) mod 26, out_char = 0x41 + index, with S = sum over i of (pos[i] + ROTOR_KEY[i]) mod 26, using positions before the step.
REQ-017 ROTOR_KEY[i] = 2*i + 1; transform is reciprocal and never maps a letter to itself.
REQ-018 On each accepted letter, rotors step odometer-style after S is sampled: pos[0] increments; pos[i+1] increments when pos[i] wraps 25 -> 0; top rotor wraps freely.
REQ-019 Pipeline: 2 stages (stage 1 registers class, x and S; stage 2 registers out_char); accept-to-out_valid latency exactly 2 cycles when not stalled.
REQ-020 Throughput one character per cycle; both stages advance when !out_valid || out_ready, otherwise whole pipeline holds.
REQ-021 in_ready = (!out_valid || out_ready) && !load.
REQ-022 While out_valid && !out_ready, out_char and out_valid held stable.
REQ-023 load sets pos[i] = start_pos field, minus 26 when field >= 26; in-flight characters finish with their already-sampled S.
REQ-024 load and in_valid in the same cycle: load wins, no accept, no step.

Reset
REQ-025 rst clears all rotor positions to 0, both pipeline valid bits to 0, out_valid to 0, out_char to 0x00.
REQ-026 rst mid-stream discards in-flight characters without emitting them; rst dominates load and accept.
REQ-027 in_ready is 0 during the rst cycle and 1 on the first cycle after (load low).

Structure
REQ-028 Shared package holds ALPHA = 26, ASCII_A = 0x41, ROTOR_KEY function/table, and the mod-26 helper.
REQ-029 One sub-module, enigma_rotor_stack: holds positions, implements load/step, exports S.
REQ-030 No memories; all logic synthesizable flip-flops and combinational arithmetic.

Verification (NUM_ROTORS=3)
REQ-031 Reset, load 0/0/0, send 'A','A' -> 'H' then 'F'; out_valid 2 cycles after each accept.
REQ-032 Reload 0/0/0, send 'H','F' -> 'A','A' (reciprocity); no output ever equals its input letter.
REQ-033 Load pos0=25, others 0, send 'A','A' -> 'J' (S=8), then rotor1=1, rotor0=0, second 'A' -> 'F' (S=10).
REQ-034 Load 0/0/0, send ' ', 'A' -> 0x20 unchanged, then 'H' (space does not step).
REQ-035 Hold out_ready=0 over 3 back-to-back letters -> out_char stable, in_ready drops after pipeline fills, order preserved on release.
REQ-036 Assert rst with two characters in flight -> neither emitted, positions 0, next 'A' -> 'H'.
